pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It watches decode operands, the EX-stage load and branch-resolution signals, and the data-memory stall, and drives the hold/flush controls of the PC, the F→D register and the D→E register. It also replays the misprediction redirect. A small FSM preserves flush state across memory stalls and flags runaway memory stalls.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flush window,
// memory-stall freeze with state preservation, and a sticky runaway-stall flag. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int XLEN            = 32,
  parameter int PC_BITS         = 12,
  parameter int REDIRECT_CYCLES = 2,
  parameter int STALL_TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         D_rs1,
  input  logic [4:0]         D_rs2,
  input  logic               D_uses_rs1,
  input  logic               D_uses_rs2,
  input  logic               EX_valid,
  input  logic               EX_is_load,
  input  logic [4:0]         EX_rd,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_target_pc,
  input  logic               MEM_stall,
  output logic               stall_F,
  output logic               stall_D,
  output logic               stall_E,
  output logic               flush_D,
  output logic               flush_E,
  output logic               redirect_valid,
  output logic [PC_BITS-1:0] redirect_pc,
  output logic               stall_timeout,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flushes
);

  localparam int TW = (STALL_TIMEOUT > 255) ? $clog2(STALL_TIMEOUT + 1) : 8;
  localparam logic [2:0] RC1 = 3'(REDIRECT_CYCLES - 1);

  typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} state_t;

  state_t            state, ret_state, eff;
  logic [2:0]        rcnt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              lu_hold, timeout_q;
  logic              hazard, lu_fire, take;
  logic              s_f, s_d, s_e, f_d, f_e, rv;
  logic [PC_BITS-1:0] pc_sel;

  // A PC wider than the datapath cannot be addressed; keep only the reachable bits.
  if (PC_BITS <= XLEN) begin : g_pc
    assign pc_sel = EX_target_pc;
  end else begin : g_pc_clip
    assign pc_sel = {{(PC_BITS-XLEN){1'b0}}, EX_target_pc[XLEN-1:0]};
  end

  // While frozen, behaviour on release follows the state we were frozen in.
  assign eff    = (state == MEM_WAIT) ? ret_state : state;
  assign hazard = EX_valid & EX_is_load & (EX_rd != 5'd0) &
                  ((D_uses_rs1 & (D_rs1 == EX_rd)) | (D_uses_rs2 & (D_rs2 == EX_rd)));
  assign take   = ~MEM_stall & EX_taken;
  // lu_hold masks the cycle after a bubble: EX then holds the bubble, not the load.
  assign lu_fire = ~MEM_stall & ~EX_taken & (eff == RUN) & hazard & ~lu_hold;

  always_comb begin
    s_f = 1'b0; s_d = 1'b0; s_e = 1'b0;
    f_d = 1'b0; f_e = 1'b0; rv  = 1'b0;
    if (MEM_stall) begin
      s_f = 1'b1; s_d = 1'b1; s_e = 1'b1;
    end else if (EX_taken) begin
      rv = 1'b1; f_d = 1'b1; f_e = 1'b1;
    end else if (eff == REDIRECT) begin
      f_d = 1'b1;
    end else if (lu_fire) begin
      s_f = 1'b1; s_d = 1'b1; f_e = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      rcnt      <= 3'd0;
      lu_hold   <= 1'b0;
    end else if (MEM_stall) begin
      if (state != MEM_WAIT) ret_state <= state;
      state <= MEM_WAIT;
    end else if (EX_taken) begin
      rcnt    <= RC1;
      state   <= (RC1 != 3'd0) ? REDIRECT : RUN;
      lu_hold <= 1'b0;
    end else begin
      lu_hold <= lu_fire;
      if (eff == REDIRECT) begin
        rcnt  <= rcnt - 3'd1;
        state <= (rcnt == 3'd1) ? RUN : REDIRECT;
      end else begin
        state <= RUN;
      end
    end
  end

  assign tcnt_nxt = MEM_stall ? ((tcnt == '1) ? tcnt : tcnt + 1'b1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt <= tcnt_nxt;
      if (MEM_stall && (tcnt_nxt == TW'(STALL_TIMEOUT))) timeout_q <= 1'b1;
    end
  end

  assign stall_F        = s_f & ~rst;
  assign stall_D        = s_d & ~rst;
  assign stall_E        = s_e & ~rst;
  assign flush_D        = f_d & ~rst;
  assign flush_E        = f_e & ~rst;
  assign redirect_valid = rv & ~rst;
  assign redirect_pc    = (rv & ~rst) ? pc_sel : '0;
  assign stall_timeout  = timeout_q & ~rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q, pflush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstall_q <= 32'd0;
      pflush_q <= 32'd0;
    end else begin
      if (s_f)  pstall_q <= pstall_q + 32'd1;
      if (take) pflush_q <= pflush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = pstall_q & {32{~rst}};
  assign perf_flushes      = pflush_q & {32{~rst}};
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flushes      = 32'd0;
`endif

endmodule
